// File: rtl/axis_tx_port_arbiter.sv
// axis_tx_port_arbiter
// Packet-granular round-robin arbiter that merges N_PORTS AXI-Stream sources
// into the single TX AXI-Stream input of the 10G MAC. A port that wins
// arbitration keeps the grant until its tlast beat, so frames never interleave.
// The output is a single registered slot. The source port number travels with
// every beat on m_axis_tid.
module axis_tx_port_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int N_SYMBOLS = 8,
    parameter int W_SYMBOL  = 8,
    parameter int W_ID      = $clog2(N_PORTS)
) (
    input  logic                                  i_tx_clk,
    input  logic                                  i_tx_reset,
    input  logic [N_PORTS-1:0]                    i_port_en,
    input  logic [N_PORTS-1:0]                    s_axis_tvalid,
    input  logic [N_PORTS*N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
    input  logic [N_PORTS*N_SYMBOLS-1:0]          s_axis_tkeep,
    input  logic [N_PORTS-1:0]                    s_axis_tlast,
    output logic [N_PORTS-1:0]                    s_axis_tready,
    output logic                                  m_axis_tvalid,
    output logic [N_SYMBOLS*W_SYMBOL-1:0]         m_axis_tdata,
    output logic [N_SYMBOLS-1:0]                  m_axis_tkeep,
    output logic                                  m_axis_tlast,
    output logic [W_ID-1:0]                       m_axis_tid,
    input  logic                                  m_axis_tready,
    output logic                                  o_busy,
    output logic [W_ID-1:0]                       o_grant_id
);

    localparam int              W_DATA    = N_SYMBOLS * W_SYMBOL;
    localparam logic [W_ID-1:0] LAST_PORT = W_ID'(N_PORTS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_reg,      state_next;
    logic [W_ID-1:0]     grant_reg,      grant_next;
    logic [W_ID-1:0]     last_grant_reg, last_grant_next;
    logic                busy_reg,       busy_next;

    logic                out_valid_reg,  out_valid_next;
    logic [W_DATA-1:0]   out_data_reg,   out_data_next;
    logic [N_SYMBOLS-1:0] out_keep_reg,  out_keep_next;
    logic                out_last_reg,   out_last_next;
    logic [W_ID-1:0]     out_id_reg,     out_id_next;

    // ------------------------------------------------------------------
    // Per-port views and arbitration helpers
    // ------------------------------------------------------------------
    logic [W_DATA-1:0]    port_data [N_PORTS];
    logic [N_SYMBOLS-1:0] port_keep [N_PORTS];

    logic [N_PORTS-1:0]   req;
    logic [N_PORTS-1:0]   grant_onehot;
    logic [N_PORTS-1:0]   upper_mask;
    logic [N_PORTS-1:0]   req_upper;
    logic [N_PORTS-1:0]   pick_vec;
    logic [N_PORTS-1:0]   pick_onehot;
    logic [W_ID-1:0]      arb_pick;
    logic [N_PORTS-1:0]   ready_vec;

    logic                 out_free;
    logic                 sel_valid;
    logic                 sel_last;
    logic [W_DATA-1:0]    sel_data;
    logic [N_SYMBOLS-1:0] sel_keep;

    assign req      = s_axis_tvalid & i_port_en;
    assign out_free = !out_valid_reg || m_axis_tready;

    // Unpack the flat input buses and build per-port decode masks.
    // upper_mask marks ports numbered above the last winner; those are
    // searched first so the search starts at last_grant+1 and wraps.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
            assign port_data[gi]    = s_axis_tdata[gi*W_DATA +: W_DATA];
            assign port_keep[gi]    = s_axis_tkeep[gi*N_SYMBOLS +: N_SYMBOLS];
            assign grant_onehot[gi] = (grant_reg == W_ID'(gi));
            assign upper_mask[gi]   = (W_ID'(gi) > last_grant_reg);
        end
    endgenerate

    // Round-robin pick: lowest requester above last_grant, else lowest overall.
    assign req_upper   = req & upper_mask;
    assign pick_vec    = (|req_upper) ? req_upper : req;
    assign pick_onehot = pick_vec & (~pick_vec + N_PORTS'(1));

    // One-hot to binary encoder for the winning port.
    generate
        for (genvar gb = 0; gb < W_ID; gb++) begin : g_enc
            logic [N_PORTS-1:0] bit_mask;
            for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_mask
                assign bit_mask[gi] = (((gi >> gb) & 1) == 1);
            end
            assign arb_pick[gb] = |(pick_onehot & bit_mask);
        end
    endgenerate

    // Beat source for the current grant.
    assign sel_valid = |(s_axis_tvalid & grant_onehot);
    assign sel_last  = |(s_axis_tlast & grant_onehot);
    assign sel_data  = port_data[grant_reg];
    assign sel_keep  = port_keep[grant_reg];

    // Next-state logic: arbitration in IDLE, beat transfer into the output slot in XFER.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        busy_next       = busy_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_keep_next   = out_keep_reg;
        out_last_next   = out_last_reg;
        out_id_next     = out_id_reg;
        ready_vec       = '0;

        // A consumed beat leaves the slot empty unless refilled below.
        if (out_free) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    grant_next = arb_pick;
                    busy_next  = 1'b1;
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                // Only the granted port sees ready, and only when the slot can take a beat.
                ready_vec = grant_onehot & {N_PORTS{out_free}};
                if (sel_valid && out_free) begin
                    out_valid_next = 1'b1;
                    out_data_next  = sel_data;
                    out_keep_next  = sel_keep;
                    out_last_next  = sel_last;
                    out_id_next    = grant_reg;
                    if (sel_last) begin
                        last_grant_next = grant_reg;
                        busy_next       = 1'b0;
                        state_next      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output register updates; reset truncates any frame in flight.
    always_ff @(posedge i_tx_clk) begin
        if (i_tx_reset) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_PORT;
            busy_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_keep_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_id_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            busy_reg       <= busy_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_keep_reg   <= out_keep_next;
            out_last_reg   <= out_last_next;
            out_id_reg     <= out_id_next;
        end
    end

    assign s_axis_tready = ready_vec;
    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tkeep  = out_keep_reg;
    assign m_axis_tlast  = out_last_reg;
    assign m_axis_tid    = out_id_reg;
    assign o_busy        = busy_reg;
    assign o_grant_id    = grant_reg;

endmodule

// File: tb/tb_axis_tx_port_arbiter.sv
// Directed testbench for axis_tx_port_arbiter (4-port and 2-port builds).
module tb_axis_tx_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   en, s_valid, s_last, s_ready;
    logic [255:0] s_data;
    logic [31:0]  s_keep;
    logic         m_valid, m_last, m_ready, busy;
    logic [63:0]  m_data;
    logic [7:0]   m_keep;
    logic [1:0]   m_id, gid;

    logic [1:0]   d2_en, d2_valid, d2_last, d2_ready;
    logic [127:0] d2_data;
    logic [15:0]  d2_keep;
    logic         d2_mvalid, d2_mlast, d2_mready, d2_busy;
    logic [63:0]  d2_mdata;
    logic [7:0]   d2_mkeep;
    logic [0:0]   d2_mid, d2_gid;

    axis_tx_port_arbiter dut (
        .i_tx_clk(clk), .i_tx_reset(rst), .i_port_en(en),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
        .s_axis_tlast(s_last), .s_axis_tready(s_ready),
        .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
        .m_axis_tlast(m_last), .m_axis_tid(m_id), .m_axis_tready(m_ready),
        .o_busy(busy), .o_grant_id(gid)
    );

    axis_tx_port_arbiter #(.N_PORTS(2)) dut2 (
        .i_tx_clk(clk), .i_tx_reset(rst), .i_port_en(d2_en),
        .s_axis_tvalid(d2_valid), .s_axis_tdata(d2_data), .s_axis_tkeep(d2_keep),
        .s_axis_tlast(d2_last), .s_axis_tready(d2_ready),
        .m_axis_tvalid(d2_mvalid), .m_axis_tdata(d2_mdata), .m_axis_tkeep(d2_mkeep),
        .m_axis_tlast(d2_mlast), .m_axis_tid(d2_mid), .m_axis_tready(d2_mready),
        .o_busy(d2_busy), .o_grant_id(d2_gid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Source model state per port.
    int rem[4], beat[4], pkt[4], len[4];
    bit cont[4], hold[4];
    // Output monitor state.
    int obeat[4], opkt[4];
    int cur_tid, idle_cnt, n_out, acc_id;
    bit in_pkt, had_acc, prev_ready, prev_stall, prev_busy, last_was_tlast, gap_chk;
    logic [3:0]  prev_en;
    logic [75:0] prev_bus;
    logic [63:0] acc_data;
    int got_order[$];
    int d2_tids[$];

    function automatic logic [63:0] mkdata(input int p, input int k, input int b);
        return {16'hA5C3, 8'(p), 8'(k), 8'(b), 24'h3C0F5A};
    endfunction

    function automatic logic [7:0] mkkeep(input int b);
        logic [7:0] f;
        f = 8'hFF;
        return f >> (b % 8);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_order(input string tag, input int q[$], input int n, input int e[5]);
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n; i++) begin
            chk(tag, (i < q.size()) ? q[i] : -1, e[i]);
        end
    endtask

    task automatic reset_model();
        for (int p = 0; p < 4; p++) begin
            rem[p] = 0; beat[p] = 0; pkt[p] = 0; len[p] = 1;
            cont[p] = 1'b0; hold[p] = 1'b0; obeat[p] = 0; opkt[p] = 0;
        end
        in_pkt = 1'b0; had_acc = 1'b0; prev_ready = 1'b0; prev_stall = 1'b0;
        prev_busy = 1'b0; last_was_tlast = 1'b0; gap_chk = 1'b0;
        idle_cnt = 0; n_out = 0; cur_tid = 0;
        got_order.delete();
        prev_en = en;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = '0;
        d2_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        reset_model();
    endtask

    // One clock cycle: drive sources, check outputs, update models, advance.
    task automatic step();
        logic [3:0] er, acc;
        logic       of;
        for (int p = 0; p < 4; p++) begin
            s_valid[p]         = (rem[p] > 0) && !hold[p];
            s_data[p*64 +: 64] = mkdata(p, pkt[p], beat[p]);
            s_keep[p*8 +: 8]   = mkkeep(beat[p]);
            s_last[p]          = (rem[p] == 1);
        end
        #1;
        of = !m_valid || m_ready;
        if (prev_stall) chk("hold_stable", {m_valid, m_last, m_id, m_keep, m_data}, prev_bus);
        if (had_acc) begin
            chk("lat_valid", m_valid, 1'b1);
            chk("lat_data", m_data, acc_data);
            chk("lat_id", m_id, acc_id);
        end else if (prev_ready) begin
            chk("drain_valid", m_valid, 1'b0);
        end
        er = '0;
        if (busy && of) er[gid] = 1'b1;
        chk("s_ready", s_ready, er);
        if (busy && !prev_busy) chk("grant_enabled", prev_en[gid], 1'b1);
        if (m_valid && m_ready) begin
            int id;
            id = int'(m_id);
            n_out++;
            if (!in_pkt) begin
                got_order.push_back(id);
                cur_tid = id;
                in_pkt  = 1'b1;
            end else begin
                chk("no_interleave", id, cur_tid);
            end
            chk("out_data", m_data, mkdata(id, opkt[id], obeat[id]));
            chk("out_keep", m_keep, mkkeep(obeat[id]));
            chk("out_last", m_last, obeat[id] == len[id] - 1);
            if (m_last) begin
                in_pkt = 1'b0; obeat[id] = 0; opkt[id]++;
            end else begin
                obeat[id]++;
            end
        end
        acc = s_valid & s_ready;
        had_acc = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (acc[p]) begin
                if (gap_chk && last_was_tlast) chk("pkt_gap", idle_cnt, 1);
                had_acc = 1'b1;
                acc_data = s_data[p*64 +: 64];
                acc_id = p;
                last_was_tlast = s_last[p];
                beat[p]++;
                rem[p]--;
                if (rem[p] == 0) begin
                    pkt[p]++;
                    beat[p] = 0;
                    if (cont[p]) rem[p] = len[p];
                end
            end
        end
        idle_cnt   = had_acc ? 0 : idle_cnt + 1;
        prev_ready = m_ready;
        prev_stall = m_valid && !m_ready;
        prev_bus   = {m_valid, m_last, m_id, m_keep, m_data};
        prev_busy  = busy;
        prev_en    = en;
        @(posedge clk); #1;
    endtask

    initial begin
        int rp[10];
        rst = 1'b1; en = 4'hF; s_valid = '0; s_data = '0; s_keep = '0; s_last = '0; m_ready = 1'b1;
        d2_en = 2'b11; d2_valid = '0; d2_data = '0; d2_keep = '0; d2_last = '0; d2_mready = 1'b1;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 64'h0);
        chk("rst_m_keep", m_keep, 8'h0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_id", m_id, 2'd0);
        chk("rst_s_ready", s_ready, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", gid, 2'd0);
        chk("rst_d2_valid", d2_mvalid, 1'b0);
        rst = 1'b0;
        reset_model();
        $display("T1: port 2 three-beat packet");
        len[2] = 3; rem[2] = 3;
        for (int i = 0; i < 8; i++) step();
        check_order("t1_order", got_order, 1, '{2, 0, 0, 0, 0});
        chk("t1_beats", n_out, 3);
        chk("t1_busy", busy, 1'b0);
        chk("t1_grant_id", gid, 2'd2);

        $display("T2: all ports continuous, 2-beat packets");
        do_reset();
        gap_chk = 1'b1;
        for (int p = 0; p < 4; p++) begin len[p] = 2; rem[p] = 2; cont[p] = 1'b1; end
        for (int i = 0; i < 100 && got_order.size() < 5; i++) step();
        check_order("t2_order", got_order, 5, '{0, 1, 2, 3, 0});

        $display("T3: port 1 with output back-pressure");
        do_reset();
        rp = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        len[1] = 4; rem[1] = 4;
        for (int i = 0; i < 14; i++) begin
            m_ready = (i < 10) ? rp[i][0] : 1'b1;
            step();
        end
        m_ready = 1'b1;
        check_order("t3_order", got_order, 1, '{1, 0, 0, 0, 0});
        chk("t3_beats", n_out, 4);
        chk("t3_pkts", opkt[1], 1);

        $display("T4a: port 2 disabled");
        en = 4'b1011;
        do_reset();
        gap_chk = 1'b1;
        for (int p = 0; p < 4; p++) begin len[p] = 2; rem[p] = 2; cont[p] = 1'b1; end
        for (int i = 0; i < 100 && got_order.size() < 4; i++) step();
        check_order("t4_order", got_order, 4, '{0, 1, 3, 0, 0});
        chk("t4_port2_pkts", pkt[2], 0);

        $display("T4b: enable dropped mid-packet");
        en = 4'b0001;
        do_reset();
        len[0] = 3; rem[0] = 3;
        for (int i = 0; i < 10 && beat[0] < 1; i++) step();
        chk("t4b_started", beat[0], 1);
        en = 4'b0000;
        hold[0] = 1'b1;
        step();
        hold[0] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_order("t4b_order", got_order, 1, '{0, 0, 0, 0, 0});
        chk("t4b_pkts", opkt[0], 1);
        chk("t4b_busy", busy, 1'b0);
        rem[0] = 3;
        for (int i = 0; i < 10; i++) step();
        chk("t4b_blocked", pkt[0], 1);
        chk("t4b_no_more", got_order.size(), 1);

        $display("T5: reset mid-packet of port 3");
        en = 4'hF;
        do_reset();
        len[3] = 4; rem[3] = 4;
        for (int i = 0; i < 10 && beat[3] < 2; i++) step();
        chk("t5_two_beats", beat[3], 2);
        chk("t5_pre_valid", m_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_m_valid", m_valid, 1'b0);
        chk("t5_s_ready", s_ready, 4'h0);
        chk("t5_busy", busy, 1'b0);
        reset_model();
        rem[0] = 1; rem[3] = 1;
        for (int i = 0; i < 12; i++) step();
        check_order("t5_order", got_order, 2, '{0, 3, 0, 0, 0});

        $display("T6: 2-port build, single-beat packets");
        do_reset();
        d2_valid = 2'b11; d2_last = 2'b11; d2_keep = 16'hFFFF;
        d2_data = {mkdata(1, 0, 0), mkdata(0, 0, 0)};
        for (int c = 0; c < 12; c++) begin
            #1;
            if (d2_mvalid) begin
                d2_tids.push_back(int'(d2_mid));
                chk("t6_last", d2_mlast, 1'b1);
                chk("t6_data", d2_mdata, mkdata(int'(d2_mid), 0, 0));
                chk("t6_keep", d2_mkeep, 8'hFF);
            end
            @(posedge clk); #1;
        end
        check_order("t6_tid", d2_tids, 5, '{0, 1, 0, 1, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
